// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, reads a zero-latency instruction
// memory and hands {pc, instr} pairs to decode through a 2-entry valid/ready queue.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_BYTES = 64,
   parameter int unsigned DEPTH      = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc_plus4,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        fetch_done,
   output logic [31:0] instr_count
);

   localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);
   localparam logic [1:0]  FULL_CNT   = 2'(DEPTH);

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [1:0][31:0] ent_pc_q, ent_instr_q;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             fetch_done_q, fetch_done_d;
   logic [31:0]      instr_count_q, instr_count_d;

   logic pop_s, fetch_ok_s, push_s;

   assign pop_s      = out_valid & out_ready;
   assign fetch_ok_s = (fetch_pc_q < IMEM_LIMIT) & ~redirect_valid;
   assign push_s     = fetch_ok_s & ((count_q < FULL_CNT) | pop_s);

   // Next-state logic; a redirect overrides every queue and PC update.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      fetch_done_d  = fetch_done_q;
      instr_count_d = pop_s ? (instr_count_q + 32'd1) : instr_count_q;
      if (redirect_valid) begin
         fetch_pc_d   = {redirect_target[31:2], 2'b00};
         wr_ptr_d     = 1'b0;
         rd_ptr_d     = 1'b0;
         count_d      = 2'd0;
         fetch_done_d = 1'b0;
      end else begin
         if (push_s) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            wr_ptr_d   = ~wr_ptr_q;
         end else begin
            fetch_pc_d = fetch_pc_q;
            wr_ptr_d   = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
         fetch_done_d = (fetch_pc_d >= IMEM_LIMIT);
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc_q    <= RESET_PC;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         count_q       <= 2'd0;
         fetch_done_q  <= 1'b0;
         instr_count_q <= 32'd0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         fetch_done_q  <= fetch_done_d;
         instr_count_q <= instr_count_d;
      end
   end

   // Queue storage, written at the tail only on a push.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ent_pc_q    <= '0;
         ent_instr_q <= '0;
      end else if (push_s) begin
         ent_pc_q[wr_ptr_q]    <= fetch_pc_q;
         ent_instr_q[wr_ptr_q] <= imem_rdata;
      end else begin
         ent_pc_q    <= ent_pc_q;
         ent_instr_q <= ent_instr_q;
      end
   end

   // Head presentation; payload forced to zero while the queue is empty.
   always_comb begin
      out_valid = (count_q != 2'd0);
      if (out_valid) begin
         out_pc       = ent_pc_q[rd_ptr_q];
         out_instr    = ent_instr_q[rd_ptr_q];
         out_pc_plus4 = ent_pc_q[rd_ptr_q] + 32'd4;
      end else begin
         out_pc       = 32'd0;
         out_instr    = 32'd0;
         out_pc_plus4 = 32'd0;
      end
   end

   assign imem_addr   = fetch_pc_q;
   assign fetch_done  = fetch_done_q;
   assign instr_count = instr_count_q;

   fetch_unit_chk u_chk (
      .clk_i            (clk),
      .reset_n_i        (reset_n),
      .count_i          (count_q),
      .out_valid_i      (out_valid),
      .out_ready_i      (out_ready),
      .out_pc_i         (out_pc),
      .redirect_valid_i (redirect_valid)
   );

endmodule

// Invariant checker for fetch_unit: occupancy bound and stable head under stall.
module fetch_unit_chk (
   input logic        clk_i,
   input logic        reset_n_i,
   input logic [1:0]  count_i,
   input logic        out_valid_i,
   input logic        out_ready_i,
   input logic [31:0] out_pc_i,
   input logic        redirect_valid_i
);

   a_count_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      count_i <= 2'd2);

   a_valid_match: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      out_valid_i == (count_i != 2'd0));

   a_head_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (out_valid_i && !out_ready_i && !redirect_valid_i) |=> (out_valid_i && $stable(out_pc_i)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan steps plus random traffic
// compared against a queue-based reference model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] imem_addr, imem_rdata;
   logic        out_valid, out_ready;
   logic [31:0] out_pc, out_instr, out_pc_plus4;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        fetch_done;
   logic [31:0] instr_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] imem [16];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc;
   logic        m_done;
   logic [31:0] m_cnt;

   fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(64), .DEPTH(2)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_instr       (out_instr),
      .out_pc_plus4    (out_pc_plus4),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .fetch_done      (fetch_done),
      .instr_count     (instr_count)
   );

   always #5 clk = ~clk;

   always_comb imem_rdata = (imem_addr < 32'd64) ? imem[imem_addr[5:2]] : 32'd0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a < 32'd64) ? imem[a[5:2]] : 32'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc   = 32'd0;
      m_done = 1'b0;
      m_cnt  = 32'd0;
   endtask

   task automatic check_outputs();
      logic        v;
      logic [31:0] hp, hi;
      v  = (mq.size() > 0);
      hp = v ? mq[0].pc : 32'd0;
      hi = v ? mq[0].instr : 32'd0;
      chk("out_valid", {31'd0, out_valid}, {31'd0, v});
      chk("out_pc", out_pc, hp);
      chk("out_instr", out_instr, hi);
      chk("out_pc_plus4", out_pc_plus4, v ? hp + 32'd4 : 32'd0);
      chk("imem_addr", imem_addr, m_pc);
      chk("fetch_done", {31'd0, fetch_done}, {31'd0, m_done});
      chk("instr_count", instr_count, m_cnt);
   endtask

   // One clock cycle: drive inputs at the falling edge, advance the model at the rising edge.
   task automatic step(input logic rdy, input logic rv, input logic [31:0] tgt);
      bit   pop, push;
      ent_t e;
      @(negedge clk);
      out_ready       = rdy;
      redirect_valid  = rv;
      redirect_target = tgt;
      pop  = (mq.size() > 0) && rdy;
      push = (m_pc < 32'd64) && !rv && ((mq.size() < 2) || pop);
      e.pc    = m_pc;
      e.instr = mem_word(m_pc);
      @(posedge clk);
      #1;
      if (pop) begin
         void'(mq.pop_front());
         m_cnt = m_cnt + 32'd1;
      end
      if (rv) begin
         mq.delete();
         m_pc   = {tgt[31:2], 2'b00};
         m_done = 1'b0;
      end else begin
         if (push) begin
            mq.push_back(e);
            m_pc = m_pc + 32'd4;
         end
         m_done = (m_pc >= 32'd64);
      end
      check_outputs();
   endtask

   // Holds reset for two edges, checks the reset state, releases just after a rising edge.
   task automatic do_reset();
      reset_n         = 1'b0;
      out_ready       = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      logic [31:0] cnt_before;
      for (int i = 0; i < 16; i++) imem[i] = $urandom;
      imem[0] = 32'h0022_1820;
      imem[1] = 32'h2109_000A;
      imem[7] = 32'h1022_0003;

      // Streaming from reset with decode always ready.
      do_reset();
      step(1'b1, 1'b0, 32'd0);
      chk("first_pc", out_pc, 32'd0);
      chk("first_instr", out_instr, 32'h0022_1820);
      step(1'b1, 1'b0, 32'd0);
      chk("second_pc", out_pc, 32'd4);
      chk("second_instr", out_instr, 32'h2109_000A);
      chk("second_plus4", out_pc_plus4, 32'd8);
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 32'd0);
      chk("stream_count", instr_count, 32'd10);

      // Backpressure saturates the queue, then drains in order.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0);
      chk("bp_addr_hold", imem_addr, 32'd8);
      chk("bp_head", out_pc, 32'd0);
      step(1'b1, 1'b0, 32'd0);
      chk("bp_drain1", out_pc, 32'd4);
      step(1'b1, 1'b0, 32'd0);
      chk("bp_drain2", out_pc, 32'd8);
      step(1'b1, 1'b0, 32'd0);
      chk("bp_drain3", out_pc, 32'd12);

      // Misaligned redirect while full.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b1, 32'h1E);
      chk("redir_valid", {31'd0, out_valid}, 32'd0);
      chk("redir_addr", imem_addr, 32'h1C);
      step(1'b0, 1'b0, 32'd0);
      chk("redir_pc", out_pc, 32'h1C);
      chk("redir_instr", out_instr, 32'h1022_0003);

      // Running off the end of instruction memory.
      step(1'b1, 1'b1, 32'h30);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0);
      chk("oor_done", {31'd0, fetch_done}, 32'd1);
      chk("oor_addr", imem_addr, 32'h40);
      step(1'b1, 1'b0, 32'd0);
      chk("oor_drained", {31'd0, out_valid}, 32'd0);
      step(1'b1, 1'b0, 32'd0);
      chk("oor_addr_hold", imem_addr, 32'h40);
      step(1'b1, 1'b1, 32'h20);
      chk("oor_resume_done", {31'd0, fetch_done}, 32'd0);
      chk("oor_resume_addr", imem_addr, 32'h20);
      step(1'b1, 1'b0, 32'd0);
      chk("oor_resume_pc", out_pc, 32'h20);

      // Simultaneous push and pop while full, then redirect with a pop.
      step(1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b0, 32'd0);
      chk("full_addr", imem_addr, 32'h28);
      step(1'b1, 1'b0, 32'd0);
      chk("pushpop_head", out_pc, 32'h24);
      chk("pushpop_addr", imem_addr, 32'h2C);
      cnt_before = instr_count;
      step(1'b1, 1'b1, 32'h10);
      chk("redir_pop_count", instr_count, cnt_before + 32'd1);
      chk("redir_pop_empty", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset between edges.
      step(1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'd0);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_valid", {31'd0, out_valid}, 32'd0);
      chk("async_addr", imem_addr, 32'd0);
      chk("async_count", instr_count, 32'd0);
      model_reset();
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      step(1'b1, 1'b0, 32'd0);
      chk("restart_pc", out_pc, 32'd0);
      chk("restart_instr", out_instr, 32'h0022_1820);
      step(1'b1, 1'b0, 32'd0);
      chk("restart_pc2", out_pc, 32'd4);

      // Random traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) != 0),
              ($urandom_range(0, 19) == 0),
              32'($urandom_range(0, 32'h50)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
